// File: rtl/hwpe_tcdm_responder.sv
// TCDM slave endpoint: grants streamer requests, backs a word-addressed memory, answers reads after LATENCY cycles.
// Optional random grant stalls are compiled in with `define HWPE_TCDM_RESPONDER_STALL_EN.
module hwpe_tcdm_responder #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NB_WORDS   = 1024,
  parameter logic [31:0]           BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned           LATENCY    = 1,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    enable_i,
  input  logic                    tcdm_req_i,
  output logic                    tcdm_gnt_o,
  input  logic [31:0]             tcdm_add_i,
  input  logic                    tcdm_wen_i,
  input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_data_i,
  output logic [DATA_WIDTH-1:0]   tcdm_r_data_o,
  output logic                    tcdm_r_valid_o,
  output logic [31:0]             n_reads_o,
  output logic [31:0]             n_writes_o,
  output logic                    addr_err_o
);

  localparam int unsigned BE_W = DATA_WIDTH/8;
  localparam int unsigned AW   = $clog2(NB_WORDS);
  localparam logic [32:0] SPAN = 33'(NB_WORDS) << 2;

  logic [DATA_WIDTH-1:0]              mem [NB_WORDS];
  logic [31:0]                        off;
  logic                               in_range;
  logic [AW-1:0]                      idx;
  logic                               stall;
  logic                               accept, rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0]              rd_word;
  logic [LATENCY:1]                   vld_pipe;
  logic [LATENCY:1][DATA_WIDTH-1:0]   dat_pipe;
  logic                               unused_off;

  // Subtracting the base first lets one unsigned compare cover both range bounds.
  assign off        = tcdm_add_i - BASE_ADDR;
  assign in_range   = {1'b0, off} < SPAN;
  assign idx        = off[AW+1:2];
  assign unused_off = ^off[1:0];

`ifdef HWPE_TCDM_RESPONDER_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      lfsr <= 16'hACE1;
    else if (clear_i) lfsr <= 16'hACE1;
    else              lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign tcdm_gnt_o = rst_ni & tcdm_req_i & enable_i & ~clear_i & ~stall;
  assign accept     = tcdm_req_i & tcdm_gnt_o;
  assign rd_acc     = accept &  tcdm_wen_i;
  assign wr_acc     = accept & ~tcdm_wen_i;
  assign rd_word    = in_range ? mem[idx] : ERR_DATA;

  always_ff @(posedge clk_i) begin
    if (wr_acc && in_range)
      for (int i = 0; i < BE_W; i++)
        if (tcdm_be_i[i]) mem[idx][8*i +: 8] <= tcdm_data_i[8*i +: 8];
  end

  // Data stages only move alongside a valid so the output word holds between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (clear_i) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_acc;
      if (rd_acc) dat_pipe[1] <= rd_word;
      for (int i = 2; i <= LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign tcdm_r_valid_o = vld_pipe[LATENCY];
  assign tcdm_r_data_o  = dat_pipe[LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_reads_o  <= '0;
      n_writes_o <= '0;
      addr_err_o <= 1'b0;
    end else if (clear_i) begin
      n_reads_o  <= '0;
      n_writes_o <= '0;
      addr_err_o <= 1'b0;
    end else begin
      if (rd_acc) n_reads_o  <= n_reads_o + 32'd1;
      if (wr_acc) n_writes_o <= n_writes_o + 32'd1;
      if (accept && !in_range) addr_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hwpe_tcdm_responder.sv
// Bench for hwpe_tcdm_responder: LATENCY=1 and LATENCY=3 instances share one stimulus stream,
// each answered against its own queue of expected {data, due cycle} records.
module tb_hwpe_tcdm_responder;
  localparam int          NB   = 64;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, enable = 1'b1;
  logic        req = 1'b0, wen = 1'b0;
  logic [31:0] add = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt1, rv1, err1, gnt3, rv3, err3;
  logic [31:0] rd1, nr1, nw1, rd3, nr3, nw3;

  hwpe_tcdm_responder #(.DATA_WIDTH(32), .NB_WORDS(NB), .BASE_ADDR(BASE), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable), .tcdm_req_i(req),
    .tcdm_gnt_o(gnt1), .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
    .tcdm_r_data_o(rd1), .tcdm_r_valid_o(rv1), .n_reads_o(nr1), .n_writes_o(nw1), .addr_err_o(err1));

  hwpe_tcdm_responder #(.DATA_WIDTH(32), .NB_WORDS(NB), .BASE_ADDR(BASE), .LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable), .tcdm_req_i(req),
    .tcdm_gnt_o(gnt3), .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
    .tcdm_r_data_o(rd3), .tcdm_r_valid_o(rv3), .n_reads_o(nr3), .n_writes_o(nw3), .addr_err_o(err3));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int due; } exp_t;
  typedef struct { logic w; logic [31:0] a; logic [3:0] b; logic [31:0] d; logic [31:0] e; } vec_t;

  exp_t        q1[$], q3[$];
  logic [31:0] model [NB];
  int          cyc = 0, errors = 0, checks = 0;
  int          grants = 0, req_cyc = 0;
  logic [31:0] exp_nr = 0, exp_nw = 0, last_rd = 0;
  logic        exp_err = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic mon(input int lat, input logic v, input logic [31:0] d);
    exp_t e;
    bit   have;
    have = (lat == 1) ? (q1.size() > 0) : (q3.size() > 0);
    if (have) e = (lat == 1) ? q1[0] : q3[0];
    if (v) begin
      if (!have) begin
        checks++; errors++;
        $display("FAIL stray_rvalid L%0d: r_valid=1 at cycle %0d, want no response", lat, cyc);
      end else begin
        if (lat == 1) void'(q1.pop_front()); else void'(q3.pop_front());
        chk($sformatf("rdata L%0d", lat), d, e.data);
        chk($sformatf("rtime L%0d", lat), 32'(cyc), 32'(e.due));
      end
    end else if (have && e.due <= cyc) begin
      checks++; errors++;
      $display("FAIL missing_rvalid L%0d: no response at cycle %0d, want one due at %0d", lat, cyc, e.due);
      if (lat == 1) void'(q1.pop_front()); else void'(q3.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(1, rv1, rd1);
    mon(3, rv3, rd3);
  end

  function automatic bit inr(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o < 32'(4*NB);
  endfunction

  function automatic logic [31:0] mrd(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return inr(a) ? model[o[7:2]] : ERRD;
  endfunction

  // Held request; returns just after the accept edge so the next call is back-to-back.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] e);
    int          n;
    bit          acc;
    exp_t        x;
    logic [31:0] o;
    n = 0; acc = 0;
    req = 1'b1; wen = w; add = a; be = b; wdata = d;
    while (!acc && n < 64) begin
      @(negedge clk);
      req_cyc++;
      if (gnt1 !== gnt3) chk("gnt_match", {31'd0, gnt3}, {31'd0, gnt1});
      if (gnt1) acc = 1;
      else begin @(posedge clk); #1; end
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL grant_timeout: no gnt within 64 cycles for add=%h, want a grant", a);
      req = 1'b0;
      return;
    end
    grants++;
    if (w) begin
      x.data = e; x.due = cyc + 1; q1.push_back(x);
      x.due  = cyc + 3;            q3.push_back(x);
      exp_nr++;
      last_rd = e;
      if (!inr(a)) exp_err = 1'b1;
    end else begin
      exp_nw++;
      if (inr(a)) begin
        o = a - BASE;
        for (int i = 0; i < 4; i++) if (b[i]) model[o[7:2]][8*i +: 8] = d[8*i +: 8];
      end else exp_err = 1'b1;
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() > 0 || q3.size() > 0) && n < 20) begin @(posedge clk); n++; end
    @(posedge clk); #1;
    chk("drain_pending", 32'(q1.size() + q3.size()), 32'd0);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, " nr L1"},  nr1, exp_nr);  chk({tag, " nr L3"},  nr3, exp_nr);
    chk({tag, " nw L1"},  nw1, exp_nw);  chk({tag, " nw L3"},  nw3, exp_nw);
    chk({tag, " err L1"}, {31'd0, err1}, {31'd0, exp_err});
    chk({tag, " err L3"}, {31'd0, err3}, {31'd0, exp_err});
  endtask

  task automatic do_clear();
    clear = 1'b1;
    while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
    while (q3.size() > 0 && q3[$].due > cyc) void'(q3.pop_back());
    exp_nr = 0; exp_nw = 0; exp_err = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  vec_t tbl[12];

  initial begin
    int s, ok;
    logic [31:0] a, d;
    tbl[0]  = '{1'b0, BASE + 32'h10, 4'hF,    32'h1234_5678, 32'h0};
    tbl[1]  = '{1'b1, BASE + 32'h10, 4'h0,    32'h0,         32'h1234_5678};
    tbl[2]  = '{1'b0, BASE + 32'h20, 4'hF,    32'h1122_3344, 32'h0};
    tbl[3]  = '{1'b0, BASE + 32'h20, 4'b0101, 32'hAABB_CCDD, 32'h0};
    tbl[4]  = '{1'b1, BASE + 32'h20, 4'h0,    32'h0,         32'h11BB_33DD};
    tbl[5]  = '{1'b0, BASE + 32'h24, 4'hF,    32'h0,         32'h0};
    tbl[6]  = '{1'b0, BASE + 32'h24, 4'b1000, 32'hFFEE_DDCC, 32'h0};
    tbl[7]  = '{1'b1, BASE + 32'h24, 4'h0,    32'h0,         32'hFF00_0000};
    tbl[8]  = '{1'b1, BASE + 32'h13, 4'h0,    32'h0,         32'h1234_5678};
    tbl[9]  = '{1'b0, BASE + 32'hFC, 4'hF,    32'hCAFE_F00D, 32'h0};
    tbl[10] = '{1'b1, BASE + 32'hFC, 4'h0,    32'h0,         32'hCAFE_F00D};
    tbl[11] = '{1'b1, BASE + 32'h20, 4'h0,    32'h0,         32'h11BB_33DD};
    for (int i = 0; i < NB; i++) model[i] = 32'h0;

    req = 1'b1;
    #12;
    chk("reset gnt L1", {31'd0, gnt1}, 32'd0);
    chk("reset gnt L3", {31'd0, gnt3}, 32'd0);
    chk("reset rvalid L1", {31'd0, rv1}, 32'd0);
    chk("reset rvalid L3", {31'd0, rv3}, 32'd0);
    chk("reset rdata L1", rd1, 32'd0);
    chk("reset rdata L3", rd3, 32'd0);
    chk_state("reset");
    req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) access(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].e);
    drain();
    chk_state("table");

    for (int i = 0; i < 8; i++) access(1'b0, BASE + 32'(4*i), 4'hF, 32'(i), 32'h0);
    s = cyc;
    for (int i = 0; i < 8; i++) access(1'b1, BASE + 32'(4*i), 4'h0, 32'h0, 32'(i));
`ifndef HWPE_TCDM_RESPONDER_STALL_EN
    chk("burst8 cycles", 32'(cyc - s), 32'd8);
`endif
    drain();
    chk("rdata hold L3", rd3, 32'd7);

    access(1'b1, BASE + 32'(4*NB), 4'h0, 32'h0, ERRD);
    access(1'b0, BASE + 32'(4*NB), 4'hF, 32'h5555_5555, 32'h0);
    access(1'b1, BASE, 4'h0, 32'h0, mrd(BASE));
    access(1'b1, BASE - 32'd4, 4'h0, 32'h0, ERRD);
    drain();
    chk_state("oor");
    do_clear();
    chk_state("clear");

    access(1'b0, BASE + 32'h14, 4'hF, 32'h5A5A_0005, 32'h0);
    drain();
    access(1'b1, BASE + 32'h14, 4'h0, 32'h0, 32'h5A5A_0005);
    access(1'b1, BASE + 32'h14, 4'h0, 32'h0, 32'h5A5A_0005);
    do_clear();
    repeat (6) @(posedge clk);
    #1;
    chk_state("flight clear");
    access(1'b1, BASE + 32'h14, 4'h0, 32'h0, 32'h5A5A_0005);
    drain();
    chk("retained hold L3", rd3, 32'h5A5A_0005);

    access(1'b1, BASE + 32'h4, 4'h0, 32'h0, 32'd1);
    access(1'b1, BASE + 32'h8, 4'h0, 32'h0, 32'd2);
    enable = 1'b0; req = 1'b1; wen = 1'b1; add = BASE + 32'hC;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("disabled gnt", {31'd0, gnt1}, 32'd0);
    end
    @(posedge clk); #1;
    req = 1'b0; enable = 1'b1;
    drain();

    for (int i = 0; i < NB; i++) access(1'b0, BASE + 32'(4*i), 4'hF, $urandom, 32'h0);
    grants = 0; req_cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      a = BASE + 32'(4*$urandom_range(0, NB - 1)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) a = BASE + 32'(4*NB) + 32'(4*$urandom_range(0, 7));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) access(1'b1, a, 4'h0, 32'h0, mrd(a));
      else                           access(1'b0, a, 4'($urandom_range(0, 15)), d, 32'h0);
    end
    chk("random grants", 32'(grants), 32'd1000);
`ifdef HWPE_TCDM_RESPONDER_STALL_EN
    ok = (grants * 100 >= req_cyc * 70 && grants * 100 <= req_cyc * 80) ? 1 : 0;
`else
    ok = (grants == req_cyc) ? 1 : 0;
`endif
    chk("grant ratio", 32'(ok), 32'd1);
    drain();
    chk_state("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish, want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hwpe_tcdm_responder.md
Name: hwpe_tcdm_responder

Overview:
- TCDM slave (responder) end of the HWPE TCDM protocol: answers req/add/wen/be/data from an HWPE streamer's TCDM master port.
- Responds with gnt and later r_valid/r_data.
- Backs a single-ported word-addressed memory array with a programmable read latency.
- Used as the memory-side endpoint for streamer source/sink ports in block-level benches and small standalone HWPE subsystems.

Parameters:
- DATA_WIDTH, 32, data word width; byte enables are DATA_WIDTH/8 bits.
- NB_WORDS, 1024, memory depth in words; power of two, at least 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.
- LATENCY, 1, cycles from an accepted read to r_valid; legal range 1..4.
- ERR_DATA, 32'hDEAD_BEEF, r_data returned for an out-of-range read.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear
- enable_i  in  1  when 0, gnt is held low
- tcdm_req_i  in  1  request
- tcdm_gnt_o  out  1  grant; the request is accepted when req & gnt
- tcdm_add_i  in  32  byte address
- tcdm_wen_i  in  1  1 = read, 0 = write
- tcdm_be_i  in  DATA_WIDTH/8  byte enables (writes only)
- tcdm_data_i  in  DATA_WIDTH  write data
- tcdm_r_data_o  out  DATA_WIDTH  read data
- tcdm_r_valid_o  out  1  read response valid
- n_reads_o  out  32  count of accepted reads
- n_writes_o  out  32  count of accepted writes
- addr_err_o  out  1  sticky flag: an out-of-range access was accepted

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - tcdm_gnt_o=0, tcdm_r_valid_o=0, tcdm_r_data_o=0, n_reads_o=0, n_writes_o=0, addr_err_o=0.
  - Response pipeline is emptied. Memory array is not reset.
- Grant: tcdm_gnt_o = tcdm_req_i & enable_i (combinational), unless stalled by the optional feature. Grant never depends on r_valid; no backpressure on responses.
- Address decode:
  - off = add - BASE_ADDR; idx = off[log2(NB_WORDS)+1:2]; add[1:0] is ignored.
  - In range iff BASE_ADDR <= add < BASE_ADDR + 4*NB_WORDS.
- Accepted write (wen=0):
  - In range: each byte i with be[i]=1 is written from data[8i+7:8i] at the clock edge; other bytes keep their value.
  - Out of range: no memory update; addr_err_o set.
  - n_writes_o += 1. No r_valid is produced.
- Accepted read (wen=1):
  - Shift register of LATENCY stages carries {valid, data}.
  - Stage-1 data is mem[idx] sampled at the accept edge, or ERR_DATA if out of range (addr_err_o also set).
  - r_valid/r_data are asserted exactly LATENCY cycles after the accept cycle, for one cycle per read, in order.
  - n_reads_o += 1.
- Back-to-back accepts on consecutive cycles are sustained at 1 per cycle.
- r_data holds its last value when r_valid=0.
- Read-after-write: a write accepted in cycle t is visible to a read accepted in cycle t+1.
- Counters wrap modulo 2^32.
- clear_i=1 (synchronous, highest priority over accepts in the same cycle):
  - Empties the pipeline (r_valid=0 next cycle).
  - Zeroes counters and addr_err_o.
  - Memory retained; gnt forced 0 during clear.
- enable_i deassert mid-stream: already-accepted reads still complete their responses.

Optional Feature:
- Macro: HWPE_TCDM_RESPONDER_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1 on reset and on clear_i, advances every cycle.
  - gnt is suppressed in any cycle where lfsr[1:0]==2'b00 (~25% stall).
  - A stalled request must be held by the master and is accepted later with unchanged data.
- When undefined: no LFSR; gnt follows the plain rule above.

Test Plan:
- Reset, then write 0x1234_5678 at BASE_ADDR+0x10 with be=4'hF, then read the same address (LATENCY=1) -> gnt=1 on both accepts; r_valid exactly 1 cycle after the read accept with r_data=0x1234_5678; n_writes_o=1, n_reads_o=1.
- Partial write be=4'b0101, data 0xAABB_CCDD over stored 0x1122_3344, then read -> r_data=0x11BB_33DD.
- LATENCY=3: 8 back-to-back reads of words 0..7 preloaded with value=index -> gnt high for 8 consecutive cycles; r_valid high for 8 consecutive cycles starting 3 cycles after the first accept; data 0..7 in order.
- Read at BASE_ADDR + 4*NB_WORDS -> r_data=0xDEAD_BEEF, addr_err_o=1 sticky. A subsequent out-of-range write leaves memory unchanged. clear_i -> addr_err_o=0 and counters 0.
- clear_i asserted while 2 reads are in flight (LATENCY=3) -> no r_valid after the clear; a later read of word 5 returns the previously written value (memory retained).
- With HWPE_TCDM_RESPONDER_STALL_EN: 1000 requests each held until granted -> all 1000 accepted; grant ratio in 70–80%; every read returns the correct data in order; no r_valid without a matching accepted read.
